maze_carver_param: RTL and testbench

Parametrised randomized depth-first maze generator for the maze display pipeline. Carves a MAZE_W x MAZE_H single-bit cell grid (1 = open path, 0 = wall), keeping a solid border. It uses an internal LFSR, an explicit backtrack stack and a start/busy/done handshake. Downstream logic consumes the grid through the flat `maze_data` bus or the registered cell read port.

---
 rtl/maze_carver_param_if.sv | 39 +++
 rtl/maze_carver_param.sv | 176 +++++++++++++++++
 tb/tb_maze_carver_param.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_carver_param_if.sv
// Port bundle for maze_carver_param: start handshake, carving status, flat grid and cell read port.
// Defining MAZE_CARVER_SEED_PORT_EN adds the per-run LFSR seed input.
interface maze_carver_param_if #(
    parameter int MAZE_W  = 16,
    parameter int MAZE_H  = 16,
    parameter int COORD_W = 5
);
    logic                     start;
    logic [COORD_W-1:0]       start_x;
    logic [COORD_W-1:0]       start_y;
`ifdef MAZE_CARVER_SEED_PORT_EN
    logic [15:0]              seed;
`endif
    logic                     busy;
    logic                     done;
    logic                     stack_ovf;
    logic [COORD_W-1:0]       curr_x;
    logic [COORD_W-1:0]       curr_y;
    logic [MAZE_W*MAZE_H-1:0] maze_data;
    logic [COORD_W-1:0]       rd_x;
    logic [COORD_W-1:0]       rd_y;
    logic                     rd_open;

    modport master (
`ifdef MAZE_CARVER_SEED_PORT_EN
        output seed,
`endif
        output start, start_x, start_y, rd_x, rd_y,
        input  busy, done, stack_ovf, curr_x, curr_y, maze_data, rd_open
    );

    modport slave (
`ifdef MAZE_CARVER_SEED_PORT_EN
        input  seed,
`endif
        input  start, start_x, start_y, rd_x, rd_y,
        output busy, done, stack_ovf, curr_x, curr_y, maze_data, rd_open
    );
endinterface

// File: rtl/maze_carver_param.sv
// Randomized depth-first maze carver with LFSR direction choice and explicit backtrack stack.
// MAZE_CARVER_SEED_PORT_EN: the LFSR reloads from bus.seed on every accepted start.
module maze_carver_param #(
    parameter int          MAZE_W      = 16,
    parameter int          MAZE_H      = 16,
    parameter int          COORD_W     = 5,
    parameter int          STACK_DEPTH = (MAZE_W-2)*(MAZE_H-2),
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    maze_carver_param_if.slave bus
);
    localparam int N_CELLS = MAZE_W * MAZE_H;
    localparam int IDX_W   = $clog2(N_CELLS);
    localparam int CW1     = COORD_W + 1;
    localparam int SP_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [15:0]    SEED_NZ   = (SEED == 16'd0) ? 16'd1 : SEED;
    localparam logic [15:0]    LFSR_MASK = 16'hB400;
    localparam logic [CW1-1:0] W_C  = CW1'(MAZE_W);
    localparam logic [CW1-1:0] H_C  = CW1'(MAZE_H);
    localparam logic [CW1-1:0] XMAX = CW1'(MAZE_W - 2);
    localparam logic [CW1-1:0] YMAX = CW1'(MAZE_H - 2);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_TRY, S_POP, S_DONE} state_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [CW1-1:0] x, input logic [CW1-1:0] y);
        return IDX_W'(int'(x) + MAZE_W * int'(y));
    endfunction

    // Coordinates are one bit wider than needed, so 0-1 wraps to a value past the grid edge.
    function automatic logic cell_at(input logic [N_CELLS-1:0] g, input logic [CW1-1:0] x,
                                     input logic [CW1-1:0] y);
        if (x >= W_C || y >= H_C) return 1'b0;
        return g[cell_idx(x, y)];
    endfunction

    function automatic logic is_interior(input logic [CW1-1:0] x, input logic [CW1-1:0] y);
        return (x >= CW1'(1)) && (x <= XMAX) && (y >= CW1'(1)) && (y <= YMAX);
    endfunction

    state_t               state, state_nxt;
    logic [15:0]          lfsr;
    logic [COORD_W-1:0]   cx, cy, sx_eff, sy_eff;
    logic [1:0]           dir0, tries, dir;
    logic [SP_W-1:0]      sp;
    // Power-of-two sized so the stack pointer indexes it without a width adapter.
    logic [2*COORD_W-1:0] stack [2**SP_W];
    logic [N_CELLS-1:0]   grid;
    logic                 ovf, rd_q;
    logic [CW1-1:0]       nx, ny;
    logic [2:0]           open_cnt;
    logic                 cand_valid, stack_full, accept, carve, ovf_set, pop;

    always_comb begin
        dir = dir0 + tries;
        nx  = {1'b0, cx};
        ny  = {1'b0, cy};
        case (dir)
            2'd0:    ny = {1'b0, cy} - CW1'(1);
            2'd1:    nx = {1'b0, cx} + CW1'(1);
            2'd2:    ny = {1'b0, cy} + CW1'(1);
            default: nx = {1'b0, cx} - CW1'(1);
        endcase
        open_cnt = 3'(cell_at(grid, nx, ny - CW1'(1))) + 3'(cell_at(grid, nx + CW1'(1), ny))
                 + 3'(cell_at(grid, nx, ny + CW1'(1))) + 3'(cell_at(grid, nx - CW1'(1), ny));
        cand_valid = is_interior(nx, ny) && !cell_at(grid, nx, ny) && (open_cnt == 3'd1);
        stack_full = (sp == SP_FULL);
        if (is_interior({1'b0, bus.start_x}, {1'b0, bus.start_y})) begin
            sx_eff = bus.start_x;
            sy_eff = bus.start_y;
        end else begin
            sx_eff = COORD_W'(1);
            sy_eff = COORD_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        carve     = 1'b0;
        ovf_set   = 1'b0;
        pop       = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                bus.done = (state == S_DONE);
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_PICK;
                end
            end
            S_PICK: begin
                bus.busy  = 1'b1;
                state_nxt = S_TRY;
            end
            S_TRY: begin
                bus.busy = 1'b1;
                if (cand_valid && !stack_full) begin
                    carve     = 1'b1;
                    state_nxt = S_PICK;
                end else begin
                    ovf_set = cand_valid;
                    if (tries == 2'd3) state_nxt = S_POP;
                end
            end
            S_POP: begin
                bus.busy = 1'b1;
                if (sp == '0) state_nxt = S_DONE;
                else begin
                    pop       = 1'b1;
                    state_nxt = S_PICK;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            lfsr  <= SEED_NZ;
            grid  <= '0;
            cx    <= '0;
            cy    <= '0;
            sp    <= '0;
            dir0  <= '0;
            tries <= '0;
            ovf   <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
            rd_q  <= cell_at(grid, {1'b0, bus.rd_x}, {1'b0, bus.rd_y});
            if (state == S_PICK) begin
                dir0  <= lfsr[1:0];
                tries <= '0;
            end
            if (state == S_TRY) tries <= tries + 2'd1;
            if (ovf_set) ovf <= 1'b1;
            if (accept) begin
`ifdef MAZE_CARVER_SEED_PORT_EN
                lfsr <= (bus.seed == 16'd0) ? 16'd1 : bus.seed;
`endif
                grid <= '0;
                grid[cell_idx({1'b0, sx_eff}, {1'b0, sy_eff})] <= 1'b1;
                ovf  <= 1'b0;
                sp   <= '0;
                cx   <= sx_eff;
                cy   <= sy_eff;
            end
            if (carve) begin
                sp                   <= sp + 1'b1;
                cx                   <= nx[COORD_W-1:0];
                cy                   <= ny[COORD_W-1:0];
                grid[cell_idx(nx, ny)] <= 1'b1;
            end
            if (pop) begin
                sp       <= sp - 1'b1;
                {cx, cy} <= stack[sp - 1'b1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (carve) stack[sp] <= {cx, cy};
    end

    assign bus.stack_ovf = ovf;
    assign bus.curr_x    = cx;
    assign bus.curr_y    = cy;
    assign bus.maze_data = grid;
    assign bus.rd_open   = rd_q;
endmodule

// File: tb/tb_maze_carver_param.sv
// Bench for maze_carver_param: 3x3, 4x4 and 16x16 instances checked against an algorithmic carving model.
// Also covers the MAZE_CARVER_SEED_PORT_EN build when that macro is defined.
module tb_maze_carver_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst3, rst4, rst16, start;
    logic [4:0]  sx, sy, rx, ry;
    int          sel;
`ifdef MAZE_CARVER_SEED_PORT_EN
    logic [15:0] seed_v;
`endif

    maze_carver_param_if #(.MAZE_W(3),  .MAZE_H(3),  .COORD_W(5)) if3 ();
    maze_carver_param_if #(.MAZE_W(4),  .MAZE_H(4),  .COORD_W(5)) if4 ();
    maze_carver_param_if #(.MAZE_W(16), .MAZE_H(16), .COORD_W(5)) if16 ();

    assign if3.start  = start & (sel == 0);
    assign if4.start  = start & (sel == 1);
    assign if16.start = start & (sel == 2);
    assign if3.start_x  = sx;  assign if3.start_y  = sy;  assign if3.rd_x  = rx;  assign if3.rd_y  = ry;
    assign if4.start_x  = sx;  assign if4.start_y  = sy;  assign if4.rd_x  = rx;  assign if4.rd_y  = ry;
    assign if16.start_x = sx;  assign if16.start_y = sy;  assign if16.rd_x = rx;  assign if16.rd_y = ry;
`ifdef MAZE_CARVER_SEED_PORT_EN
    assign if3.seed = seed_v;  assign if4.seed = seed_v;  assign if16.seed = seed_v;
`endif

    maze_carver_param #(.MAZE_W(3),  .MAZE_H(3),  .COORD_W(5)) u3  (.clk(clk), .rst_n(rst3),  .bus(if3));
    maze_carver_param #(.MAZE_W(4),  .MAZE_H(4),  .COORD_W(5)) u4  (.clk(clk), .rst_n(rst4),  .bus(if4));
    maze_carver_param #(.MAZE_W(16), .MAZE_H(16), .COORD_W(5)) u16 (.clk(clk), .rst_n(rst16), .bus(if16));

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Free-running reference LFSRs, one per instance, following each reset.
    logic [15:0] trk3, trk4, trk16;
    always @(posedge clk) trk3  <= !rst3  ? 16'hACE1 : lfsr_adv(trk3);
    always @(posedge clk) trk4  <= !rst4  ? 16'hACE1 : lfsr_adv(trk4);
    always @(posedge clk) trk16 <= !rst16 ? 16'hACE1 : lfsr_adv(trk16);

    logic         busy_m, done_m, ovf_m, rdo_m;
    logic [4:0]   cxm, cym;
    logic [255:0] grid_m;
    logic [15:0]  trk_m;
    always_comb begin
        case (sel)
            0: begin
                busy_m = if3.busy; done_m = if3.done; ovf_m = if3.stack_ovf; rdo_m = if3.rd_open;
                cxm = if3.curr_x; cym = if3.curr_y; grid_m = 256'(if3.maze_data); trk_m = trk3;
            end
            1: begin
                busy_m = if4.busy; done_m = if4.done; ovf_m = if4.stack_ovf; rdo_m = if4.rd_open;
                cxm = if4.curr_x; cym = if4.curr_y; grid_m = 256'(if4.maze_data); trk_m = trk4;
            end
            default: begin
                busy_m = if16.busy; done_m = if16.done; ovf_m = if16.stack_ovf; rdo_m = if16.rd_open;
                cxm = if16.curr_x; cym = if16.curr_y; grid_m = 256'(if16.maze_data); trk_m = trk16;
            end
        endcase
    end

    typedef struct { logic [255:0] grid; int cyc; int fx; int fy; } exp_t;
    typedef struct { int dut; int gap; int sx; int sy; int seed; int ex; int ey; int pop; bit mid; } run_t;
    typedef struct { int x; int y; int exp; } rd_t;

    exp_t sb [$];
    exp_t last_exp;
    run_t tbl [32];
    int   nt;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mcell(input logic [255:0] g, input int x, input int y, input int w, input int h);
        if (x < 0 || y < 0 || x >= w || y >= h) return 0;
        return int'(g[8'(x + w * y)]);
    endfunction

    // Border, 2x2-open and 4-connectivity checks; returns a bitmask of violations.
    function automatic int inv_errs(input logic [255:0] g, input int w, input int h);
        int err = 0;
        int first = -1;
        logic [255:0] reach = '0;
        bit grow = 1'b1;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (mcell(g, x, y, w, h) == 1) begin
                    if (x == 0 || y == 0 || x == w-1 || y == h-1) err |= 1;
                    if (first < 0) first = x + w * y;
                end
                if (mcell(g, x, y, w, h) + mcell(g, x+1, y, w, h) + mcell(g, x, y+1, w, h)
                    + mcell(g, x+1, y+1, w, h) == 4) err |= 2;
            end
        if (first >= 0) reach[8'(first)] = 1'b1;
        while (grow) begin
            grow = 1'b0;
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++)
                    if (mcell(g, x, y, w, h) == 1 && mcell(reach, x, y, w, h) == 0 &&
                        (mcell(reach, x-1, y, w, h) + mcell(reach, x+1, y, w, h) +
                         mcell(reach, x, y-1, w, h) + mcell(reach, x, y+1, w, h)) > 0) begin
                        reach[8'(x + w * y)] = 1'b1;
                        grow = 1'b1;
                    end
        end
        if (reach != g) err |= 4;
        return err;
    endfunction

    // Algorithmic carve: final grid, edges from accept to done, and final position.
    task automatic model_run(input int w, input int h, input int sx0, input int sy0,
                             input logic [15:0] l1, output exp_t e);
        int cx, cy, d0, d, nx, ny, no;
        int qx [$];
        int qy [$];
        logic [15:0] l = l1;
        bit moved;
        int depth = (w - 2) * (h - 2);
        if (!(sx0 >= 1 && sx0 <= w-2 && sy0 >= 1 && sy0 <= h-2)) begin sx0 = 1; sy0 = 1; end
        e.grid = '0;
        e.grid[8'(sx0 + w * sy0)] = 1'b1;
        e.cyc = 0;
        cx = sx0; cy = sy0;
        while (1) begin
            d0 = int'(l[1:0]); l = lfsr_adv(l); e.cyc++;
            moved = 1'b0;
            for (int t = 0; t < 4 && !moved; t++) begin
                d  = (d0 + t) % 4;
                nx = cx + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
                ny = cy + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
                l = lfsr_adv(l); e.cyc++;
                no = mcell(e.grid, nx, ny-1, w, h) + mcell(e.grid, nx+1, ny, w, h)
                   + mcell(e.grid, nx, ny+1, w, h) + mcell(e.grid, nx-1, ny, w, h);
                if (nx >= 1 && nx <= w-2 && ny >= 1 && ny <= h-2 && mcell(e.grid, nx, ny, w, h) == 0
                    && no == 1 && qx.size() < depth) begin
                    qx.push_back(cx); qy.push_back(cy);
                    cx = nx; cy = ny;
                    e.grid[8'(nx + w * ny)] = 1'b1;
                    moved = 1'b1;
                end
            end
            if (!moved) begin
                l = lfsr_adv(l); e.cyc++;
                if (qx.size() == 0) break;
                cx = qx.pop_back();
                cy = qy.pop_back();
            end
        end
        e.fx = cx; e.fy = cy;
    endtask

    task automatic add_run(input int dut, input int gap, input int sx0, input int sy0, input int seed,
                           input int ex, input int ey, input int pop, input bit mid);
        tbl[nt] = '{dut, gap, sx0, sy0, seed, ex, ey, pop, mid};
        nt++;
    endtask

    task automatic chk_reset_state(input string tag);
        chk_i({tag, "_busy"},  int'(busy_m), 0);
        chk_i({tag, "_done"},  int'(done_m), 0);
        chk_i({tag, "_ovf"},   int'(ovf_m),  0);
        chk_v({tag, "_grid"},  grid_m, '0);
        chk_i({tag, "_curr_x"}, int'(cxm), 0);
        chk_i({tag, "_curr_y"}, int'(cym), 0);
        chk_i({tag, "_rd_open"}, int'(rdo_m), 0);
    endtask

    task automatic do_run(input run_t r);
        exp_t e;
        logic [15:0] l1;
        int n = 0;
        int w;
        bit seen = 1'b0;
        @(negedge clk);
        sel = r.dut;
        w = (r.dut == 0) ? 3 : (r.dut == 1) ? 4 : 16;
`ifdef MAZE_CARVER_SEED_PORT_EN
        seed_v = 16'(r.seed);
`endif
        repeat (r.gap) @(negedge clk);
        sx = 5'(r.sx); sy = 5'(r.sy); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef MAZE_CARVER_SEED_PORT_EN
        l1 = (seed_v == 16'd0) ? 16'd1 : seed_v;
`else
        l1 = trk_m;
`endif
        model_run(w, w, r.sx, r.sy, l1, e);
        sb.push_back(e);
        chk_i("busy_after_start", int'(busy_m), 1);
        chk_i("done_cleared_on_start", int'(done_m), 0);
        while (!seen && n < 20000) begin
            if (r.mid && n == 4) begin start = 1'b1; sx = 5'd2; sy = 5'd2; end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (r.mid && n == 5) chk_i("busy_ignores_start", int'(busy_m), 1);
            seen = done_m;
        end
        chk_i("done_within_budget", int'(seen), 1);
        e = sb.pop_front();
        last_exp = e;
        chk_i("cycles_to_done", n, e.cyc);
        chk_v("maze_data", grid_m, e.grid);
        chk_i("busy_low_at_done", int'(busy_m), 0);
        chk_i("stack_ovf", int'(ovf_m), 0);
        chk_i("curr_x_final", int'(cxm), r.ex);
        chk_i("curr_y_final", int'(cym), r.ey);
        chk_i("invariants", inv_errs(grid_m, w, w), 0);
        if (r.pop >= 0) chk_i("popcount", $countones(grid_m), r.pop);
        if (r.dut == 0) begin
            chk_i("cycles_3x3", n, 6);
            chk_v("grid_3x3", grid_m, 256'h10);
        end
        @(negedge clk);
        chk_i("done_held", int'(done_m), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    rd_t rds [9];

    initial begin
        start = 1'b0; sx = '0; sy = '0; rx = '0; ry = '0; sel = 0;
        rst3 = 1'b0; rst4 = 1'b0; rst16 = 1'b0;
`ifdef MAZE_CARVER_SEED_PORT_EN
        seed_v = 16'h1234;
`endif
        nt = 0;
        add_run(0, 2, 1, 1, 16'h0001, 1, 1, 1, 1'b0);
        add_run(0, 5, 0, 0, 16'h00A5, 1, 1, 1, 1'b0);
        for (int i = 0; i < 20; i++) add_run(1, i + 1, 1, 1, i + 7, 1, 1, 3, 1'b0);
        add_run(2, 3, 4, 4, 16'h1234, 4, 4, -1, 1'b1);
        add_run(2, 2, 0, 15, 16'h5A5A, 1, 1, -1, 1'b0);
        add_run(2, 7, 4, 4, 16'hBEEF, 4, 4, -1, 1'b0);
        rds = '{'{4, 4, 1}, '{20, 4, 0}, '{20, 0, 0}, '{0, 0, 0}, '{15, 15, 0},
                '{31, 31, 0}, '{5, 4, -1}, '{4, 5, -1}, '{8, 8, -1}};

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_reset_state("reset");
        end
        @(negedge clk);
        rst3 = 1'b1; rst4 = 1'b1; rst16 = 1'b1;

        for (int i = 0; i < nt; i++) do_run(tbl[i]);

        // Read port against the last 16x16 model grid, including the registered latency.
        @(negedge clk);
        rx = 5'd20; ry = 5'd4;
        @(posedge clk); #1;
        @(negedge clk);
        rx = 5'd4; ry = 5'd4;
        #1;
        chk_i("rd_open_latency_pre", int'(rdo_m), 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rx = 5'(rds[i].x); ry = 5'(rds[i].y);
            @(posedge clk); #1;
            chk_i("rd_open", int'(rdo_m),
                  (rds[i].exp >= 0) ? rds[i].exp : mcell(last_exp.grid, rds[i].x, rds[i].y, 16, 16));
        end

        // Single-edge reset in mid-run, with a coincident start that must be ignored.
        @(negedge clk);
        sel = 2; rx = 5'd4; ry = 5'd4; sx = 5'd4; sy = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst16 = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_reset_state("midrun_reset");
        @(negedge clk);
        rst16 = 1'b1;
        #1;
        chk_i("no_start_during_reset", int'(busy_m), 0);
        begin
            run_t r;
            r = '{2, 4, 4, 4, 16'h0042, 4, 4, -1, 1'b0};
            do_run(r);
`ifdef MAZE_CARVER_SEED_PORT_EN
            begin
                logic [255:0] g_a;
                r = '{2, 2, 4, 4, 16'h1234, 4, 4, -1, 1'b0};
                do_run(r);
                g_a = last_exp.grid;
                r = '{2, 11, 4, 4, 16'h1234, 4, 4, -1, 1'b0};
                do_run(r);
                chk_v("seed_repeatable_model", last_exp.grid, g_a);
                r = '{2, 3, 4, 4, 16'h0001, 4, 4, -1, 1'b0};
                do_run(r);
                r = '{2, 6, 4, 4, 16'h0000, 4, 4, -1, 1'b0};
                do_run(r);
            end
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
